// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared load funct3 encodings, FSM state type and access-size decode
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0_REQ,
    ST_RD0_WAIT,
    ST_RD1_REQ,
    ST_RD1_WAIT,
    ST_RESP
  } lsu_state_t;

  // A size of 0 marks an illegal load funct3.
  function automatic logic [2:0] load_size(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: load_size = 3'd1;
      F3_LH, F3_LHU: load_size = 3'd2;
      F3_LW:         load_size = 3'd4;
      default:       load_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - shifts {hi,lo} right by the byte offset, then narrows and sign/zero-extends
module load_extract
  import lsu_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;
  logic [2:0]  w_size;
  logic        w_signed;
  logic        w_unused_top;

  assign w_size   = load_size(i_funct3);
  assign w_signed = ~i_funct3[2];
  // Offset 3 with a word access ends at byte 6, so the top byte never reaches the result.
  assign w_unused_top = ^i_data[63:56];

  always_comb begin
    w_shifted = i_data[31:0];
    case (i_offset)
      2'd1:    w_shifted = i_data[39:8];
      2'd2:    w_shifted = i_data[47:16];
      2'd3:    w_shifted = i_data[55:24];
      default: w_shifted = i_data[31:0];
    endcase
  end

  always_comb begin
    o_data = w_shifted;
    case (w_size)
      3'd1:    o_data = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
      3'd2:    o_data = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - LSU load aligner: word reads, byte merge, extend, timeout
// Define LSU_LOAD_ALIGN_MISALIGN_EN to support misaligned and word-crossing loads.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int MEM_LAT_MAX = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_funct3,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err
);

  localparam int TMO_W = $clog2(MEM_LAT_MAX + 1);

  lsu_state_t        r_state;
  lsu_state_t        w_state_next;
  logic [1:0]        r_offset;
  logic [2:0]        r_funct3;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_rsp_data;
  logic              r_rsp_err;
  logic [TMO_W-1:0]  r_tmo;

  logic [2:0]        w_size;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_tmo_hit;
  logic [31:0]       w_lo;
  logic [31:0]       w_hi;
  logic [31:0]       w_extract;

  assign w_size    = load_size(i_req_funct3);
  assign w_illegal = (w_size == 3'd0);
  assign w_tmo_hit = (r_tmo == TMO_W'(MEM_LAT_MAX));

`ifdef LSU_LOAD_ALIGN_MISALIGN_EN
  logic [31:0] r_lo;
  logic        w_cross;

  assign w_misalign = 1'b0;
  assign w_cross    = ({2'b00, r_offset} + {1'b0, load_size(r_funct3)}) > 4'd4;
  assign w_lo       = (r_state == ST_RD1_WAIT) ? r_lo : i_mem_rdata;
  assign w_hi       = (r_state == ST_RD1_WAIT) ? i_mem_rdata : 32'd0;
`else
  assign w_misalign = ((w_size == 3'd2) && i_req_addr[0]) ||
                      ((w_size == 3'd4) && (i_req_addr[1:0] != 2'b00));
  assign w_lo       = i_mem_rdata;
  assign w_hi       = 32'd0;
`endif

  load_extract u_extract (
    .i_data   ({w_hi, w_lo}),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_data   (w_extract)
  );

  always_comb begin
    w_state_next = r_state;
    o_req_ready  = 1'b0;
    o_mem_valid  = 1'b0;
    o_rsp_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_state_next = (w_illegal || w_misalign) ? ST_RESP : ST_RD0_REQ;
        end
      end
      ST_RD0_REQ: begin
        o_mem_valid = 1'b1;
        if (i_mem_ready) w_state_next = ST_RD0_WAIT;
      end
      ST_RD0_WAIT: begin
        if (i_mem_rvalid) begin
`ifdef LSU_LOAD_ALIGN_MISALIGN_EN
          w_state_next = w_cross ? ST_RD1_REQ : ST_RESP;
`else
          w_state_next = ST_RESP;
`endif
        end else if (w_tmo_hit) begin
          w_state_next = ST_RESP;
        end
      end
`ifdef LSU_LOAD_ALIGN_MISALIGN_EN
      ST_RD1_REQ: begin
        o_mem_valid = 1'b1;
        if (i_mem_ready) w_state_next = ST_RD1_WAIT;
      end
      ST_RD1_WAIT: begin
        if (i_mem_rvalid || w_tmo_hit) w_state_next = ST_RESP;
      end
`endif
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_offset   <= 2'd0;
      r_funct3   <= 3'd0;
      r_mem_addr <= 32'd0;
      r_rsp_data <= 32'd0;
      r_rsp_err  <= 1'b0;
      r_tmo      <= '0;
`ifdef LSU_LOAD_ALIGN_MISALIGN_EN
      r_lo       <= 32'd0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_offset   <= i_req_addr[1:0];
            r_funct3   <= i_req_funct3;
            r_mem_addr <= {i_req_addr[31:2], 2'b00};
            r_tmo      <= '0;
            if (w_illegal || w_misalign) begin
              r_rsp_data <= 32'd0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        ST_RD0_WAIT, ST_RD1_WAIT: begin
          if (i_mem_rvalid) begin
            r_tmo <= '0;
`ifdef LSU_LOAD_ALIGN_MISALIGN_EN
            // Second word sits at the next word address; 32-bit add wraps at the top of memory.
            if (w_state_next == ST_RD1_REQ) begin
              r_lo       <= i_mem_rdata;
              r_mem_addr <= r_mem_addr + 32'd4;
            end
`endif
            if (w_state_next == ST_RESP) begin
              r_rsp_data <= w_extract;
              r_rsp_err  <= 1'b0;
            end
          end else if (w_tmo_hit) begin
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr = r_mem_addr;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_err  = r_rsp_err;

endmodule
